// File: rtl/stack_seq_arbiter.sv
// Shared CALL/RET/INT/RTI stack sequencer that owns the stack pointer and
// arbitrates the single data-memory port against memory-stage accesses.
module stack_seq_arbiter #(
   parameter int unsigned          DATA_W  = 16,
   parameter int unsigned          ADDR_W  = 20,
   parameter logic [ADDR_W-1:0]    SP_INIT = 20'hFFFFF,
   parameter logic [2*DATA_W-1:0]  INT_VEC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_call,
   input  logic                 req_ret,
   input  logic                 req_int,
   input  logic                 req_rti,
   output logic                 ack_call,
   output logic                 ack_ret,
   output logic                 ack_int,
   output logic                 ack_rti,
   input  logic [2*DATA_W-1:0]  pc_in,
   input  logic [2*DATA_W-1:0]  target_in,
   input  logic [3:0]           ccr_in,
   input  logic                 pipe_rd,
   input  logic                 pipe_wr,
   input  logic                 pipe_push,
   input  logic                 pipe_pop,
   input  logic [ADDR_W-1:0]    pipe_addr,
   input  logic [DATA_W-1:0]    pipe_wdata,
   output logic                 pipe_stall,
   output logic                 busy,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [2*DATA_W-1:0]  pc_out,
   output logic                 pc_load,
   output logic [3:0]           ccr_out,
   output logic                 ccr_load,
   output logic [ADDR_W-1:0]    sp_out
);

   localparam int unsigned       PC_W    = 2 * DATA_W;
   localparam logic [ADDR_W-1:0] SP_STEP = ADDR_W'(1);

   typedef enum logic [2:0] {
      IDLE, PUSH_H, PUSH_L, PUSH_CCR, POP_CCR, POP_L, POP_H, LOAD
   } state_t;

   typedef enum logic [1:0] {K_CALL, K_RET, K_INT, K_RTI} kind_t;

   state_t             state, state_nxt;
   kind_t              kind, acc_kind;
   logic               accept;
   logic [ADDR_W-1:0]  sp, sp_nxt, sp_inc, sp_dec;
   logic [PC_W-1:0]    pc_lat, tgt_lat;
   logic [3:0]         ccr_lat;
   logic               pipe_any;

   assign sp_inc   = sp + SP_STEP;
   assign sp_dec   = sp - SP_STEP;
   assign pipe_any = pipe_rd | pipe_wr | pipe_push | pipe_pop;

   // Fixed-priority acceptance, only while idle and out of reset
   always_comb begin
      ack_int  = 1'b0;
      ack_rti  = 1'b0;
      ack_ret  = 1'b0;
      ack_call = 1'b0;
      accept   = 1'b0;
      acc_kind = K_CALL;
      if (state == IDLE && !rst) begin
         accept = 1'b1;
         if (req_int) begin
            ack_int  = 1'b1;
            acc_kind = K_INT;
         end else if (req_rti) begin
            ack_rti  = 1'b1;
            acc_kind = K_RTI;
         end else if (req_ret) begin
            ack_ret  = 1'b1;
            acc_kind = K_RET;
         end else if (req_call) begin
            ack_call = 1'b1;
            acc_kind = K_CALL;
         end else begin
            accept = 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (acc_kind)
                  K_RET:   state_nxt = POP_L;
                  K_RTI:   state_nxt = POP_CCR;
                  default: state_nxt = PUSH_H;
               endcase
            end
         end
         PUSH_H:   state_nxt = PUSH_L;
         PUSH_L:   state_nxt = (kind == K_INT) ? PUSH_CCR : LOAD;
         PUSH_CCR: state_nxt = LOAD;
         POP_CCR:  state_nxt = POP_L;
         POP_L:    state_nxt = POP_H;
         POP_H:    state_nxt = LOAD;
         LOAD:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Memory port: pipeline owns it in IDLE, the sequence owns it otherwise
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      sp_nxt    = sp;
      case (state)
         IDLE: begin
            if (pipe_push) begin
               mem_wr    = 1'b1;
               mem_addr  = sp;
               mem_wdata = pipe_wdata;
               sp_nxt    = sp_dec;
            end else if (pipe_pop) begin
               mem_rd    = 1'b1;
               mem_addr  = sp_inc;
               sp_nxt    = sp_inc;
            end else if (pipe_wr) begin
               mem_wr    = 1'b1;
               mem_addr  = pipe_addr;
               mem_wdata = pipe_wdata;
            end else if (pipe_rd) begin
               mem_rd    = 1'b1;
               mem_addr  = pipe_addr;
            end
         end
         PUSH_H: begin
            mem_wr    = 1'b1;
            mem_addr  = sp;
            mem_wdata = pc_lat[PC_W-1:DATA_W];
            sp_nxt    = sp_dec;
         end
         PUSH_L: begin
            mem_wr    = 1'b1;
            mem_addr  = sp;
            mem_wdata = pc_lat[DATA_W-1:0];
            sp_nxt    = sp_dec;
         end
         PUSH_CCR: begin
            mem_wr    = 1'b1;
            mem_addr  = sp;
            mem_wdata = {{(DATA_W-4){1'b0}}, ccr_lat};
            sp_nxt    = sp_dec;
         end
         POP_CCR, POP_L, POP_H: begin
            mem_rd    = 1'b1;
            mem_addr  = sp_inc;
            sp_nxt    = sp_inc;
         end
         default: ;
      endcase
   end

   // Popped halves overwrite the latched PC; nothing else reads it after accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         kind    <= K_CALL;
         sp      <= SP_INIT;
         pc_lat  <= '0;
         tgt_lat <= '0;
         ccr_lat <= '0;
      end else begin
         state <= state_nxt;
         sp    <= sp_nxt;
         if (accept) begin
            kind    <= acc_kind;
            pc_lat  <= pc_in;
            tgt_lat <= target_in;
            ccr_lat <= ccr_in;
         end
         case (state)
            POP_CCR: ccr_lat                <= mem_rdata[3:0];
            POP_L:   pc_lat[DATA_W-1:0]     <= mem_rdata;
            POP_H:   pc_lat[PC_W-1:DATA_W]  <= mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      pc_out = '0;
      if (state == LOAD) begin
         case (kind)
            K_CALL:  pc_out = tgt_lat;
            K_INT:   pc_out = INT_VEC;
            default: pc_out = pc_lat;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign pipe_stall = busy & pipe_any;
   assign pc_load    = (state == LOAD);
   assign ccr_load   = (state == LOAD) && (kind == K_RTI);
   assign ccr_out    = ccr_load ? ccr_lat : 4'h0;
   assign sp_out     = sp;

endmodule

// File: tb/tb_stack_seq_arbiter.sv
// Directed bench for stack_seq_arbiter: per-cycle expectations are queued as
// stimulus is driven and popped against the DUT outputs on the falling edge.
module tb_stack_seq_arbiter;

   localparam logic [3:0] A_NONE = 4'b0000;
   localparam logic [3:0] A_CALL = 4'b0001;
   localparam logic [3:0] A_RET  = 4'b0010;
   localparam logic [3:0] A_RTI  = 4'b0100;
   localparam logic [3:0] A_INT  = 4'b1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_call, req_ret, req_int, req_rti;
   logic        ack_call, ack_ret, ack_int, ack_rti;
   logic [31:0] pc_in, target_in;
   logic [3:0]  ccr_in;
   logic        pipe_rd, pipe_wr, pipe_push, pipe_pop;
   logic [19:0] pipe_addr;
   logic [15:0] pipe_wdata;
   logic        pipe_stall, busy;
   logic        mem_rd, mem_wr;
   logic [19:0] mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic [31:0] pc_out;
   logic        pc_load;
   logic [3:0]  ccr_out;
   logic        ccr_load;
   logic [19:0] sp_out;

   typedef struct {
      logic [3:0]  ack;
      logic        bsy;
      logic        stl;
      logic        rd;
      logic        wr;
      logic [19:0] a;
      logic [15:0] d;
      logic        pl;
      logic [31:0] pc;
      logic        cl;
      logic [3:0]  cc;
      logic [19:0] sp;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          ncyc     = 0;
   logic [15:0] mem [16] = '{default: 16'h0000};
   logic [19:0] s;

   always #5 clk = ~clk;

   // Small memory: the addresses used by the bench are distinct in their low nibble
   assign mem_rdata = mem[mem_addr[3:0]];
   always @(posedge clk) if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;

   stack_seq_arbiter dut (
      .clk(clk), .rst(rst),
      .req_call(req_call), .req_ret(req_ret), .req_int(req_int), .req_rti(req_rti),
      .ack_call(ack_call), .ack_ret(ack_ret), .ack_int(ack_int), .ack_rti(ack_rti),
      .pc_in(pc_in), .target_in(target_in), .ccr_in(ccr_in),
      .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_push(pipe_push), .pipe_pop(pipe_pop),
      .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
      .pipe_stall(pipe_stall), .busy(busy),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .pc_out(pc_out), .pc_load(pc_load), .ccr_out(ccr_out), .ccr_load(ccr_load),
      .sp_out(sp_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ex(input logic [3:0] ack, input logic bsy, input logic stl,
                     input logic rd, input logic wr, input logic [19:0] a,
                     input logic [15:0] d, input logic pl, input logic [31:0] pc,
                     input logic cl, input logic [3:0] cc, input logic [19:0] sp);
      exp_t e;
      e.ack = ack; e.bsy = bsy; e.stl = stl; e.rd = rd; e.wr = wr; e.a = a;
      e.d = d; e.pl = pl; e.pc = pc; e.cl = cl; e.cc = cc; e.sp = sp;
      sb.push_back(e);
   endtask

   task automatic idle(input logic [19:0] sp);
      ex(A_NONE, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, sp);
   endtask

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      ncyc++;
      checks++;
      assert (sb.size() != 0) else begin
         failures++;
         $error("FAIL sb_empty cyc=%0d observed=0 expected=1", ncyc);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk($sformatf("ctl@%0d", ncyc),
             {ack_int, ack_rti, ack_ret, ack_call, busy, pipe_stall, pc_load, ccr_load},
             {e.ack, e.bsy, e.stl, e.pl, e.cl});
         chk($sformatf("bus@%0d", ncyc),
             {mem_rd, mem_wr, mem_addr, (mem_wr ? mem_wdata : 16'h0)},
             {e.rd, e.wr, e.a, e.d});
         chk($sformatf("pc_out@%0d", ncyc), pc_out, e.pc);
         chk($sformatf("ccr_out@%0d", ncyc), ccr_out, e.cc);
         chk($sformatf("sp@%0d", ncyc), sp_out, e.sp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst = 1'b1;
      {req_call, req_ret, req_int, req_rti} = 4'b0;
      {pipe_rd, pipe_wr, pipe_push, pipe_pop} = 4'b0;
      pc_in = 32'h0; target_in = 32'h0; ccr_in = 4'h0;
      pipe_addr = 20'h0; pipe_wdata = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      idle(20'hFFFFF); cycle();

      // CALL from SP=FFFFF
      req_call = 1'b1; pc_in = 32'h0001_0234; target_in = 32'h0000_0500;
      ex(A_CALL, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      req_call = 1'b0;
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFF, 16'h0001, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFE, 16'h0234, 0, 32'h0, 0, 4'h0, 20'hFFFFE); cycle();
      ex(A_NONE, 1, 0, 0, 0, 20'h0, 16'h0, 1, 32'h0000_0500, 0, 4'h0, 20'hFFFFD); cycle();
      chk("mem_FFFFF", mem[15], 16'h0001);
      chk("mem_FFFFE", mem[14], 16'h0234);

      // RET straight after
      req_ret = 1'b1;
      ex(A_RET, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFD); cycle();
      req_ret = 1'b0;
      ex(A_NONE, 1, 0, 1, 0, 20'hFFFFE, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFD); cycle();
      ex(A_NONE, 1, 0, 1, 0, 20'hFFFFF, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFE); cycle();
      ex(A_NONE, 1, 0, 0, 0, 20'h0, 16'h0, 1, 32'h0001_0234, 0, 4'h0, 20'hFFFFF); cycle();

      // INT then RTI
      req_int = 1'b1; ccr_in = 4'b1010; pc_in = 32'h0000_0042;
      ex(A_INT, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      req_int = 1'b0;
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFF, 16'h0000, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFE, 16'h0042, 0, 32'h0, 0, 4'h0, 20'hFFFFE); cycle();
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFD, 16'h000A, 0, 32'h0, 0, 4'h0, 20'hFFFFD); cycle();
      ex(A_NONE, 1, 0, 0, 0, 20'h0, 16'h0, 1, 32'h0000_0000, 0, 4'h0, 20'hFFFFC); cycle();
      req_rti = 1'b1; pc_in = 32'hDEAD_BEEF; ccr_in = 4'h0;
      ex(A_RTI, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFC); cycle();
      req_rti = 1'b0;
      ex(A_NONE, 1, 0, 1, 0, 20'hFFFFD, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFC); cycle();
      ex(A_NONE, 1, 0, 1, 0, 20'hFFFFE, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFD); cycle();
      ex(A_NONE, 1, 0, 1, 0, 20'hFFFFF, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFE); cycle();
      ex(A_NONE, 1, 0, 0, 0, 20'h0, 16'h0, 1, 32'h0000_0042, 1, 4'b1010, 20'hFFFFF); cycle();

      // INT beats CALL, pipe_wr served in the accept cycle, pipe_rd stalls while busy
      req_int = 1'b1; req_call = 1'b1; pipe_wr = 1'b1;
      pipe_addr = 20'h00003; pipe_wdata = 16'h5A5A;
      pc_in = 32'h0000_1111; target_in = 32'h0000_2222; ccr_in = 4'b0101;
      ex(A_INT, 0, 0, 0, 1, 20'h00003, 16'h5A5A, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      req_int = 1'b0; pipe_wr = 1'b0; pipe_rd = 1'b1; pipe_addr = 20'h00007;
      pc_in = 32'h0000_3333; target_in = 32'h0000_4444;
      ex(A_NONE, 1, 1, 0, 1, 20'hFFFFF, 16'h0000, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      pipe_rd = 1'b0;
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFE, 16'h1111, 0, 32'h0, 0, 4'h0, 20'hFFFFE); cycle();
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFD, 16'h0005, 0, 32'h0, 0, 4'h0, 20'hFFFFD); cycle();
      ex(A_NONE, 1, 0, 0, 0, 20'h0, 16'h0, 1, 32'h0000_0000, 0, 4'h0, 20'hFFFFC); cycle();
      ex(A_CALL, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFC); cycle();
      req_call = 1'b0;
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFC, 16'h0000, 0, 32'h0, 0, 4'h0, 20'hFFFFC); cycle();
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFB, 16'h3333, 0, 32'h0, 0, 4'h0, 20'hFFFFB); cycle();
      ex(A_NONE, 1, 0, 0, 0, 20'h0, 16'h0, 1, 32'h0000_4444, 0, 4'h0, 20'hFFFFA); cycle();
      chk("mem_00003", mem[3], 16'h5A5A);

      // Walk SP to 0 with pops, then push/pop across the wrap
      for (int i = 0; i < 6; i++) begin
         pipe_pop = 1'b1;
         s = 20'hFFFFA + 20'(i);
         ex(A_NONE, 0, 0, 1, 0, s + 20'd1, 16'h0, 0, 32'h0, 0, 4'h0, s); cycle();
      end
      pipe_push = 1'b1; pipe_wr = 1'b1; pipe_rd = 1'b1;
      pipe_addr = 20'h00009; pipe_wdata = 16'h1234;
      ex(A_NONE, 0, 0, 0, 1, 20'h00000, 16'h1234, 0, 32'h0, 0, 4'h0, 20'h00000); cycle();
      pipe_push = 1'b0;
      ex(A_NONE, 0, 0, 1, 0, 20'h00000, 16'h0, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      pipe_pop = 1'b0;
      ex(A_NONE, 0, 0, 0, 1, 20'h00009, 16'h1234, 0, 32'h0, 0, 4'h0, 20'h00000); cycle();
      pipe_wr = 1'b0; pipe_rd = 1'b0;
      chk("mem_00000", mem[0], 16'h1234);

      // Reset during PUSH_L of a CALL
      req_call = 1'b1; pc_in = 32'h0000_ABCD; target_in = 32'h0000_9999;
      ex(A_CALL, 0, 0, 0, 0, 20'h0, 16'h0, 0, 32'h0, 0, 4'h0, 20'h00000); cycle();
      req_call = 1'b0;
      ex(A_NONE, 1, 0, 0, 1, 20'h00000, 16'h0000, 0, 32'h0, 0, 4'h0, 20'h00000); cycle();
      rst = 1'b1;
      ex(A_NONE, 1, 0, 0, 1, 20'hFFFFF, 16'hABCD, 0, 32'h0, 0, 4'h0, 20'hFFFFF); cycle();
      rst = 1'b0;
      idle(20'hFFFFF); cycle();
      idle(20'hFFFFF); cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
